// File: rtl/data_cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_cache_ctrl_pkg
//  Description : Shared FSM state encoding and default geometry for the
//                data-side cache controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_cache_ctrl_pkg;

    // Controller states; encodings are fixed so they match the I-side cache
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

    localparam int LINES_DEFAULT  = 4;
    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;

endpackage : data_cache_ctrl_pkg
`default_nettype wire

// File: rtl/dm_cache_array.sv
`default_nettype none
// ============================================================================
//  Module      : dm_cache_array
//  Description : Direct-mapped valid/tag/data storage. One combinational
//                read port and one synchronous write port. Only the valid
//                bits are reset; tag and data contents persist.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_cache_array #(
    parameter int LINES   = 4,
    parameter int INDEX_W = 2,
    parameter int TAG_W   = 28,
    parameter int DATA_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    // read port
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    // write port
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_set_valid
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

    // Valid bits: cleared asynchronously, set on a line fill
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en && wr_set_valid) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag/data storage: written on fill or store hit, never reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

endmodule : dm_cache_array
`default_nettype wire

// File: rtl/data_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_cache_ctrl
//  Description : Direct-mapped, write-through, write-update-on-hit,
//                no-write-allocate data cache controller for the MEM stage.
//                Stalls the pipeline while a miss or write-through is in
//                flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_cache_ctrl
    import data_cache_ctrl_pkg::*;
#(
    parameter int LINES  = LINES_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    // CPU side
    input  logic              cpu_req_valid,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              cpu_stall,
    // backing memory side
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;

    state_t state;

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [ADDR_W-1:0]  req_addr_aligned;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [DATA_W-1:0]  rd_data;
    logic               hit;
    logic               fill;
    logic               store_hit;
    logic               arr_we;
    logic [INDEX_W-1:0] arr_index;
    logic [TAG_W-1:0]   arr_tag;
    logic [DATA_W-1:0]  arr_data;
    logic               unused_addr_bits;

    assign req_index        = cpu_req_addr[INDEX_W+1:2];
    assign req_tag          = cpu_req_addr[ADDR_W-1:INDEX_W+2];
    assign req_addr_aligned = {cpu_req_addr[ADDR_W-1:2], 2'b00};
    assign unused_addr_bits = ^cpu_req_addr[1:0];

    assign hit       = rd_valid && (rd_tag == req_tag);
    assign cpu_stall = (state != IDLE);

    // Array writes: line fill on read response, or write-update on store hit.
    // During a fill the outstanding address is still held in mem_req_addr.
    assign fill      = (state == RD_WAIT) && mem_resp_valid;
    assign store_hit = (state == IDLE) && cpu_req_valid && cpu_req_we && hit;
    assign arr_we    = fill || store_hit;
    assign arr_index = fill ? mem_req_addr[INDEX_W+1:2]        : req_index;
    assign arr_tag   = fill ? mem_req_addr[ADDR_W-1:INDEX_W+2] : req_tag;
    assign arr_data  = fill ? mem_resp_rdata                   : cpu_req_wdata;

    dm_cache_array #(
        .LINES   (LINES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_array (
        .clock        (clock),
        .reset        (reset),
        .rd_index     (req_index),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_data      (rd_data),
        .wr_en        (arr_we),
        .wr_index     (arr_index),
        .wr_tag       (arr_tag),
        .wr_data      (arr_data),
        .wr_set_valid (fill)
    );

    // Controller FSM with registered CPU response and memory request outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cpu_resp_valid <= 1'b0;
            cpu_resp_rdata <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_we     <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wdata  <= '0;
        end else begin
            cpu_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        if (cpu_req_we) begin
                            // every store goes through to memory
                            state         <= WR_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= 1'b1;
                            mem_req_addr  <= req_addr_aligned;
                            mem_req_wdata <= cpu_req_wdata;
                        end else if (hit) begin
                            cpu_resp_valid <= 1'b1;
                            cpu_resp_rdata <= rd_data;
                        end else begin
                            state         <= RD_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= 1'b0;
                            mem_req_addr  <= req_addr_aligned;
                        end
                    end
                end
                RD_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_resp_valid) begin
                        state          <= IDLE;
                        cpu_resp_valid <= 1'b1;
                        cpu_resp_rdata <= mem_resp_rdata;
                    end
                end
                WR_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_req_we    <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : data_cache_ctrl
`default_nettype wire

// File: tb/tb_data_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_cache_ctrl
//  Description : Self-checking bench for data_cache_ctrl with a scoreboard
//                of expected load data and expected memory requests, and a
//                behavioural backing memory with programmable latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache_ctrl;

    localparam int LINES  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_req_valid;
    logic              cpu_req_we;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [DATA_W-1:0] cpu_req_wdata;
    logic              cpu_resp_valid;
    logic [DATA_W-1:0] cpu_resp_rdata;
    logic              cpu_stall;
    logic              mem_req_valid;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    data_cache_ctrl #(
        .LINES  (LINES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_we     (cpu_req_we),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .cpu_stall      (cpu_stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memreq_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    memreq_t     exp_mq[$];
    logic [31:0] exp_rq[$];
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] mem_store [logic [31:0]];
    bit          auto_mem  = 1'b1;
    int          rdy_dly   = 2;
    int          resp_dly  = 1;
    int          hs_count  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Issue one CPU request and wait for the controller to finish it
    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit exp_hit);
        int cnt;
        @(negedge clock);
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        if (we) begin
            exp_mq.push_back('{1'b1, {addr[31:2], 2'b00}, wdata});
            ref_mem[{addr[31:2], 2'b00}] = wdata;
        end else begin
            exp_rq.push_back(ref_mem[{addr[31:2], 2'b00}]);
            if (!exp_hit) exp_mq.push_back('{1'b0, {addr[31:2], 2'b00}, 32'h0});
        end
        @(posedge clock);
        #1;
        cpu_req_valid = 1'b0;
        if (!we && exp_hit) begin
            chk("hit_no_stall", 64'(cpu_stall), 64'(0));
            chk("hit_no_memreq", 64'(mem_req_valid), 64'(0));
            @(negedge clock);
            chk("hit_resp_valid", 64'(cpu_resp_valid), 64'(1));
        end else begin
            chk("stall_rise", 64'(cpu_stall), 64'(1));
            cnt = 0;
            @(negedge clock);
            while (cpu_stall && cnt < 200) begin
                @(negedge clock);
                cnt++;
            end
            if (cnt >= 200) chk("stall_timeout", 64'(1), 64'(0));
            if (!we) chk("miss_resp_with_stall_fall", 64'(cpu_resp_valid), 64'(1));
            else     chk("store_no_resp", 64'(cpu_resp_valid), 64'(0));
        end
    endtask

    // Response monitor: every load response is matched against the scoreboard
    always @(negedge clock) begin
        if (!reset && cpu_resp_valid) begin
            if (exp_rq.size() == 0) chk("spurious_resp", 64'(1), 64'(0));
            else                    chk("resp_data", 64'(cpu_resp_rdata), 64'(exp_rq.pop_front()));
        end
    end

    // Backing memory model: delayed ready, hold checks, delayed read data
    initial begin
        memreq_t snap;
        memreq_t e;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        forever begin
            @(negedge clock);
            if (auto_mem && !reset && mem_req_valid) begin
                snap = '{mem_req_we, mem_req_addr, mem_req_wdata};
                for (int k = 0; k < rdy_dly - 1; k++) begin
                    @(negedge clock);
                    chk("req_hold_valid", 64'(mem_req_valid), 64'(1));
                    chk("req_hold_fields", 64'({mem_req_we, mem_req_addr}), 64'({snap.we, snap.addr}));
                    chk("req_hold_wdata", 64'(mem_req_wdata), 64'(snap.wdata));
                end
                if (exp_mq.size() == 0) begin
                    chk("unexpected_memreq", 64'(1), 64'(0));
                end else begin
                    e = exp_mq.pop_front();
                    chk("memreq_we", 64'(snap.we), 64'(e.we));
                    chk("memreq_addr", 64'(snap.addr), 64'(e.addr));
                    if (e.we) chk("memreq_wdata", 64'(snap.wdata), 64'(e.wdata));
                end
                mem_req_ready = 1'b1;
                hs_count++;
                @(negedge clock);
                mem_req_ready = 1'b0;
                if (snap.we) begin
                    mem_store[snap.addr] = snap.wdata;
                end else begin
                    for (int k = 0; k < resp_dly - 1; k++) @(negedge clock);
                    mem_resp_rdata = mem_store.exists(snap.addr) ? mem_store[snap.addr] : 32'h0;
                    mem_resp_valid = 1'b1;
                    @(negedge clock);
                    mem_resp_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        reset         = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
        mem_store[32'h00] = 32'hA5A5_0000;  ref_mem[32'h00] = 32'hA5A5_0000;
        mem_store[32'h10] = 32'hDEAD_BEEF;  ref_mem[32'h10] = 32'hDEAD_BEEF;
        mem_store[32'h20] = 32'h2020_2020;  ref_mem[32'h20] = 32'h2020_2020;
        mem_store[32'h40] = 32'h4040_4040;  ref_mem[32'h40] = 32'h4040_4040;
        repeat (2) @(negedge clock);
        chk("rst_stall", 64'(cpu_stall), 64'(0));
        chk("rst_resp_valid", 64'(cpu_resp_valid), 64'(0));
        chk("rst_resp_rdata", 64'(cpu_resp_rdata), 64'(0));
        chk("rst_mem_req", 64'({mem_req_valid, mem_req_we}), 64'(0));
        chk("rst_mem_addr", 64'(mem_req_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_req_wdata), 64'(0));
        reset = 1'b0;
        @(negedge clock);

        // cold miss, then repeat hit
        rdy_dly = 2; resp_dly = 1;
        do_req(1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 1'b1);
        // byte offset ignored on hit
        do_req(1'b0, 32'h13, 32'h0, 1'b1);

        // store hit updates the line, load hits with new data
        rdy_dly = 3; resp_dly = 2;
        do_req(1'b1, 32'h10, 32'h1234_5678, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 1'b1);

        // conflict misses on index 0
        h0 = hs_count;
        do_req(1'b0, 32'h00, 32'h0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b0, 32'h00, 32'h0, 1'b0);
        chk("conflict_reads", 64'(hs_count - h0), 64'(3));

        // store miss: no allocate, line for 0x00 untouched
        rdy_dly = 1; resp_dly = 3;
        do_req(1'b1, 32'h20, 32'hCAFE_F00D, 1'b0);
        do_req(1'b0, 32'h00, 32'h0, 1'b1);
        do_req(1'b0, 32'h20, 32'h0, 1'b0);

        // reset while waiting for read data
        auto_mem = 1'b0;
        @(negedge clock);
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = 32'h40;
        @(posedge clock);
        #1;
        cpu_req_valid = 1'b0;
        @(negedge clock);
        chk("abort_req_valid", 64'(mem_req_valid), 64'(1));
        chk("abort_req_addr", 64'(mem_req_addr), 64'(32'h40));
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        chk("abort_in_rd_wait", 64'({cpu_stall, mem_req_valid}), 64'(2'b10));
        #2 reset = 1'b1;
        #1;
        chk("abort_stall", 64'(cpu_stall), 64'(0));
        chk("abort_outputs", 64'({cpu_resp_valid, mem_req_valid, mem_req_we}), 64'(0));
        chk("abort_addr", 64'(mem_req_addr), 64'(0));
        chk("abort_rdata", 64'(cpu_resp_rdata), 64'(0));
        @(negedge clock);
        reset          = 1'b0;
        mem_resp_rdata = 32'h9999_9999;
        mem_resp_valid = 1'b1;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        chk("late_resp_ignored", 64'({cpu_resp_valid, cpu_stall}), 64'(0));
        auto_mem = 1'b1;
        rdy_dly  = 2; resp_dly = 1;
        do_req(1'b0, 32'h40, 32'h0, 1'b0);
        do_req(1'b0, 32'h00, 32'h0, 1'b0);

        repeat (4) @(negedge clock);
        chk("memreq_queue_empty", 64'(exp_mq.size()), 64'(0));
        chk("resp_queue_empty", 64'(exp_rq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_data_cache_ctrl
`default_nettype wire
